operand_registers: RTL and testbench

Parametrised two-operand entry register file for the hex calculator, the successor to the fixed 4-digit `Registers` block. It sits between the keypad decoder (single-cycle strobes) and the ALU/display path. It builds operand V1 then V2 from hex digit strobes, and supports backspace, sign toggle and clear-entry. It loads the ALU answer back into V1 on equals or on a chained operator, and tracks digit count so that entry saturates at `NDIG` digits.

---
 rtl/calc_pkg.sv | 34 +++
 rtl/operand_entry.sv | 75 +++++++
 rtl/operand_registers.sv | 139 +++++++++++++
 tb/tb_operand_registers.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the hex calculator operand path.
package calc_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned NDIG_DEFAULT = 4;

  // Entry FSM state: which operand is being edited, or result held in V1.
  typedef enum logic [1:0] {
    S_V1  = 2'd0,
    S_V2  = 2'd1,
    S_RES = 2'd2
  } state_e;

  // One operation per cycle applied to an operand_entry instance.
  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpClear = 3'd1,
    OpLoad  = 3'd2,
    OpShift = 3'd3,
    OpBack  = 3'd4,
    OpNeg   = 3'd5
  } entry_op_e;

  // Number of significant hex digits in a magnitude (up to 16 digits).
  function automatic logic [7:0] sig_digits(input logic [63:0] mag);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < 16; i++) begin
      if (mag[4*i +: 4] != 4'h0) n = 8'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/operand_entry.sv
// One operand: sign/magnitude register plus significant-digit count.
module operand_entry
  import calc_pkg::*;
#(
  parameter  int unsigned NDIG = NDIG_DEFAULT,
  localparam int unsigned MW   = DIGIT_W * NDIG,
  localparam int unsigned VW   = MW + 1,
  localparam int unsigned CW   = $clog2(NDIG + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  entry_op_e       op_i,
  input  logic [3:0]      digit_i,
  input  logic [VW-1:0]   load_val_i,
  input  logic [CW-1:0]   load_cnt_i,
  output logic [VW-1:0]   value_o,
  output logic            full_next_o,
  output logic            zero_o
);

  logic [MW-1:0] mag_q, mag_d;
  logic          sign_q, sign_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state for the selected operation; leading zeros are not counted.
  always_comb begin
    mag_d  = mag_q;
    sign_d = sign_q;
    cnt_d  = cnt_q;
    case (op_i)
      OpClear: begin
        mag_d  = '0;
        sign_d = 1'b0;
        cnt_d  = '0;
      end
      OpLoad: begin
        mag_d  = load_val_i[MW-1:0];
        sign_d = load_val_i[VW-1];
        cnt_d  = load_cnt_i;
      end
      OpShift: begin
        if (cnt_q < CW'(NDIG) && !(mag_q == '0 && digit_i == 4'h0)) begin
          mag_d = {mag_q[MW-DIGIT_W-1:0], digit_i};
          cnt_d = cnt_q + 1'b1;
        end
      end
      OpBack: begin
        mag_d = mag_q >> DIGIT_W;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (mag_d == '0) sign_d = 1'b0;
      end
      // Zero-magnitude guard is applied by the caller via zero_o.
      OpNeg:   sign_d = ~sign_q;
      default: ;
    endcase
  end

  // Operand state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mag_q  <= mag_d;
      sign_q <= sign_d;
      cnt_q  <= cnt_d;
    end
  end

  assign value_o     = {sign_q, mag_q};
  assign full_next_o = (cnt_d == CW'(NDIG));
  assign zero_o      = (mag_q == '0);

endmodule

// File: rtl/operand_registers.sv
// Two-operand entry register file: FSM and strobe priority decode.
module operand_registers
  import calc_pkg::*;
#(
  parameter  int unsigned NDIG = NDIG_DEFAULT,
  localparam int unsigned VW   = DIGIT_W * NDIG + 1,
  localparam int unsigned CW   = $clog2(NDIG + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          newhex,
  input  logic [3:0]    hexcode,
  input  logic          newop,
  input  logic          eq,
  input  logic          BS,
  input  logic          neg,
  input  logic          clr,
  input  logic [VW-1:0] answer,
  output logic [VW-1:0] V1curr,
  output logic [VW-1:0] V2curr,
  output logic          edit2,
  output logic          full
);

  state_e        state_q, state_d;
  entry_op_e     op1, op2;
  logic [VW-1:0] ld1_val;
  logic [CW-1:0] ld1_cnt, ans_cnt;
  logic          full1_next, full2_next, zero1, zero2;
  logic          edit2_q, edit2_d, full_q, full_d;

  assign ans_cnt = CW'(sig_digits(64'(answer[VW-2:0])));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_V1;
    else       state_q <= state_d;
  end

  // Next state and operand ops; strobe priority clr > eq > newop > BS > neg > newhex.
  always_comb begin
    state_d = state_q;
    op1     = OpNone;
    op2     = OpNone;
    ld1_val = answer;
    ld1_cnt = ans_cnt;
    if (clr) begin
      case (state_q)
        S_V1:    op1 = OpClear;
        S_V2:    op2 = OpClear;
        default: begin
          op1     = OpClear;
          op2     = OpClear;
          state_d = S_V1;
        end
      endcase
    end else if (eq) begin
      op1     = OpLoad;
      op2     = OpClear;
      state_d = S_RES;
    end else if (newop) begin
      // Chained operator folds the pending result into V1.
      if (state_q == S_V2) op1 = OpLoad;
      op2     = OpClear;
      state_d = S_V2;
    end else if (BS) begin
      if (state_q == S_V1)      op1 = OpBack;
      else if (state_q == S_V2) op2 = OpBack;
    end else if (neg) begin
      if (state_q == S_V2) begin
        if (!zero2) op2 = OpNeg;
      end else if (!zero1) begin
        op1 = OpNeg;
      end
    end else if (newhex) begin
      case (state_q)
        S_V1:    op1 = OpShift;
        S_V2:    op2 = OpShift;
        default: begin
          // First digit after a result starts a fresh V1.
          op1     = OpLoad;
          ld1_val = VW'(hexcode);
          ld1_cnt = (hexcode != 4'h0) ? CW'(1) : CW'(0);
          op2     = OpClear;
          state_d = S_V1;
        end
      endcase
    end
  end

  // Output flags from next state so they register alongside the operands.
  always_comb begin
    edit2_d = (state_d == S_V2);
    case (state_d)
      S_V1:    full_d = full1_next;
      S_V2:    full_d = full2_next;
      default: full_d = 1'b0;
    endcase
  end

  // Registered output flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      edit2_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      edit2_q <= edit2_d;
      full_q  <= full_d;
    end
  end

  operand_entry #(.NDIG(NDIG)) u_v1 (
    .clk_i       (clock),
    .rst_i       (reset),
    .op_i        (op1),
    .digit_i     (hexcode),
    .load_val_i  (ld1_val),
    .load_cnt_i  (ld1_cnt),
    .value_o     (V1curr),
    .full_next_o (full1_next),
    .zero_o      (zero1)
  );

  operand_entry #(.NDIG(NDIG)) u_v2 (
    .clk_i       (clock),
    .rst_i       (reset),
    .op_i        (op2),
    .digit_i     (hexcode),
    .load_val_i  (answer),
    .load_cnt_i  (ans_cnt),
    .value_o     (V2curr),
    .full_next_o (full2_next),
    .zero_o      (zero2)
  );

  assign edit2 = edit2_q;
  assign full  = full_q;

endmodule

// File: tb/tb_operand_registers.sv
// Bench for operand_registers (NDIG=4): directed scenarios plus random strobes vs a model.
module tb_operand_registers;

  logic        clock = 1'b0;
  logic        reset, newhex, newop, eq, BS, neg, clr;
  logic [3:0]  hexcode;
  logic [16:0] answer;
  logic [16:0] V1curr, V2curr;
  logic        edit2, full;

  int tests = 0;
  int fails = 0;

  // Reference model: 0 = editing V1, 1 = editing V2, 2 = result held.
  int m_st;
  int m1, m2, c1, c2;
  bit s1, s2;

  operand_registers #(.NDIG(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .newhex  (newhex),
    .hexcode (hexcode),
    .newop   (newop),
    .eq      (eq),
    .BS      (BS),
    .neg     (neg),
    .clr     (clr),
    .answer  (answer),
    .V1curr  (V1curr),
    .V2curr  (V2curr),
    .edit2   (edit2),
    .full    (full)
  );

  always #5 clock = ~clock;

  function automatic void m_digit(inout int mag, inout int cnt, input int d);
    if (cnt < 4 && !(mag == 0 && d == 0)) begin
      mag = (mag * 16 + d) % 65536;
      cnt = cnt + 1;
    end
  endfunction

  function automatic void m_back(inout int mag, inout int cnt, inout bit s);
    mag = mag / 16;
    if (cnt > 0) cnt = cnt - 1;
    if (mag == 0) s = 1'b0;
  endfunction

  function automatic void model(input bit r, c, e, o, b, n, h, input int hc,
                                input logic [16:0] ans);
    if (r) begin
      m_st = 0; m1 = 0; m2 = 0; c1 = 0; c2 = 0; s1 = 0; s2 = 0;
    end else if (c) begin
      if (m_st != 1) begin m1 = 0; c1 = 0; s1 = 0; end
      if (m_st != 0) begin m2 = 0; c2 = 0; s2 = 0; end
      if (m_st == 2) m_st = 0;
    end else if (e) begin
      m1 = int'(ans[15:0]); s1 = ans[16];
      m2 = 0; c2 = 0; s2 = 0; m_st = 2;
    end else if (o) begin
      if (m_st == 1) begin m1 = int'(ans[15:0]); s1 = ans[16]; end
      m2 = 0; c2 = 0; s2 = 0; m_st = 1;
    end else if (b) begin
      if (m_st == 0) m_back(m1, c1, s1);
      else if (m_st == 1) m_back(m2, c2, s2);
    end else if (n) begin
      if (m_st == 1) begin if (m2 != 0) s2 = ~s2; end
      else if (m1 != 0) s1 = ~s1;
    end else if (h) begin
      if (m_st == 0) m_digit(m1, c1, hc);
      else if (m_st == 1) m_digit(m2, c2, hc);
      else begin
        m1 = hc; s1 = 0; c1 = (hc != 0) ? 1 : 0;
        m2 = 0; s2 = 0; c2 = 0; m_st = 0;
      end
    end
  endfunction

  task automatic step(input bit r, c, e, o, b, n, h, input logic [3:0] hc,
                      input logic [16:0] ans);
    reset = r; clr = c; eq = e; newop = o; BS = b; neg = n; newhex = h;
    hexcode = hc; answer = ans;
    @(posedge clock);
    model(r, c, e, o, b, n, h, int'(hc), ans);
    #1;
    reset = 0; clr = 0; eq = 0; newop = 0; BS = 0; neg = 0; newhex = 0;
  endtask

  task automatic hex(input logic [3:0] d);
    step(0, 0, 0, 0, 0, 0, 1, d, 17'h0);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0, 0, 4'h0, 17'h0);
    step(1, 0, 0, 0, 0, 0, 0, 4'h0, 17'h0);
    tests++; if (V1curr !== 17'h0) begin fails++; $display("FAIL reset_v1 got %h want 0", V1curr); end
    tests++; if (V2curr !== 17'h0) begin fails++; $display("FAIL reset_v2 got %h want 0", V2curr); end
    tests++; if (edit2 !== 1'b0) begin fails++; $display("FAIL reset_edit2 got %b want 0", edit2); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
  endtask

  task automatic test_entry;
    hex(4'h3); hex(4'h2);
    tests++; if (V1curr !== 17'h00032) begin fails++; $display("FAIL entry_v1 got %h want 00032", V1curr); end
    tests++; if (edit2 !== 1'b0) begin fails++; $display("FAIL entry_edit2a got %b want 0", edit2); end
    step(0, 0, 0, 1, 0, 0, 0, 4'h0, 17'h1FFFF);
    tests++; if (edit2 !== 1'b1) begin fails++; $display("FAIL entry_edit2b got %b want 1", edit2); end
    tests++; if (V2curr !== 17'h0) begin fails++; $display("FAIL entry_v2zero got %h want 0", V2curr); end
    tests++; if (V1curr !== 17'h00032) begin fails++; $display("FAIL entry_v1keep got %h want 00032", V1curr); end
    hex(4'h1); hex(4'h1);
    tests++; if (V2curr !== 17'h00011) begin fails++; $display("FAIL entry_v2 got %h want 00011", V2curr); end
  endtask

  task automatic test_eq;
    step(0, 0, 1, 0, 0, 0, 0, 4'h0, 17'h0001A);
    tests++; if (V1curr !== 17'h0001A) begin fails++; $display("FAIL eq_v1 got %h want 0001a", V1curr); end
    tests++; if (V2curr !== 17'h0) begin fails++; $display("FAIL eq_v2 got %h want 0", V2curr); end
    tests++; if (edit2 !== 1'b0 || full !== 1'b0) begin fails++; $display("FAIL eq_flags got %b%b want 00", edit2, full); end
    hex(4'h5);
    tests++; if (V1curr !== 17'h00005) begin fails++; $display("FAIL res_digit got %h want 00005", V1curr); end
    hex(4'h6);  // proves S_V1: digit now appends
    tests++; if (V1curr !== 17'h00056) begin fails++; $display("FAIL res_append got %h want 00056", V1curr); end
  endtask

  task automatic test_saturate;
    step(0, 1, 0, 0, 0, 0, 0, 4'h0, 17'h0);
    tests++; if (V1curr !== 17'h0) begin fails++; $display("FAIL clr_v1 got %h want 0", V1curr); end
    hex(4'h0); hex(4'h0); hex(4'h7);
    tests++; if (V1curr !== 17'h00007) begin fails++; $display("FAIL lead0 got %h want 00007", V1curr); end
    hex(4'h1); hex(4'h2); hex(4'h3);
    tests++; if (V1curr !== 17'h07123 || full !== 1'b1) begin fails++; $display("FAIL sat_full got %h/%b want 07123/1", V1curr, full); end
    hex(4'h4); hex(4'h9);
    tests++; if (V1curr !== 17'h07123) begin fails++; $display("FAIL sat_ignore got %h want 07123", V1curr); end
    step(0, 0, 0, 0, 1, 0, 0, 4'h0, 17'h0);
    tests++; if (V1curr !== 17'h00712 || full !== 1'b0) begin fails++; $display("FAIL sat_bs got %h/%b want 00712/0", V1curr, full); end
  endtask

  task automatic test_chain;
    step(0, 0, 0, 1, 0, 0, 0, 4'h0, 17'h0);
    hex(4'h5);
    tests++; if (V2curr !== 17'h00005) begin fails++; $display("FAIL chain_v2 got %h want 00005", V2curr); end
    step(0, 0, 0, 1, 0, 0, 0, 4'h0, 17'h000AB);
    tests++; if (V1curr !== 17'h000AB || V2curr !== 17'h0 || edit2 !== 1'b1) begin
      fails++; $display("FAIL chain got %h/%h/%b want 000ab/00000/1", V1curr, V2curr, edit2);
    end
  endtask

  task automatic test_neg;
    step(1, 0, 0, 0, 0, 0, 0, 4'h0, 17'h0);
    hex(4'h1); hex(4'h2);
    step(0, 0, 0, 0, 0, 1, 0, 4'h0, 17'h0);
    tests++; if (V1curr !== 17'h10012) begin fails++; $display("FAIL neg_set got %h want 10012", V1curr); end
    step(0, 0, 0, 0, 1, 0, 0, 4'h0, 17'h0);
    step(0, 0, 0, 0, 1, 0, 0, 4'h0, 17'h0);
    tests++; if (V1curr !== 17'h00000) begin fails++; $display("FAIL neg_bsclr got %h want 00000", V1curr); end
    step(0, 0, 0, 0, 0, 1, 0, 4'h0, 17'h0);
    tests++; if (V1curr !== 17'h00000) begin fails++; $display("FAIL neg_zero got %h want 00000", V1curr); end
  endtask

  task automatic test_priority;
    step(0, 0, 1, 0, 0, 0, 1, 4'h9, 17'h00003);
    tests++; if (V1curr !== 17'h00003 || edit2 !== 1'b0) begin fails++; $display("FAIL prio_eq got %h/%b want 00003/0", V1curr, edit2); end
    hex(4'h4); hex(4'h5); step(0, 0, 0, 1, 0, 0, 0, 4'h0, 17'h0); hex(4'h8);
    step(1, 0, 0, 0, 0, 0, 1, 4'hC, 17'h0);
    tests++; if ({V1curr, V2curr, edit2, full} !== 36'h0) begin
      fails++; $display("FAIL prio_reset got %h/%h/%b/%b want all 0", V1curr, V2curr, edit2, full);
    end
    hex(4'h4); step(0, 0, 0, 1, 0, 0, 0, 4'h0, 17'h0); hex(4'h2);
    step(0, 0, 1, 0, 0, 0, 0, 4'h0, 17'h10021);
    step(0, 1, 0, 0, 0, 0, 0, 4'h0, 17'h0);
    tests++; if (V1curr !== 17'h0 || V2curr !== 17'h0 || edit2 !== 1'b0) begin
      fails++; $display("FAIL clr_res got %h/%h/%b want 0/0/0", V1curr, V2curr, edit2);
    end
  endtask

  task automatic test_random;
    bit r, c, e, o, b, n, h;
    int k;
    logic [16:0] ev1, ev2;
    bit ef;
    step(1, 0, 0, 0, 0, 0, 0, 4'h0, 17'h0);
    for (int i = 0; i < 600; i++) begin
      r = 0; c = 0; e = 0; o = 0; b = 0; n = 0; h = 0;
      k = $urandom_range(0, 99);
      if (k < 45) h = 1;
      else if (k < 55) b = 1;
      else if (k < 63) n = 1;
      else if (k < 73) o = 1;
      else if (k < 80) e = 1;
      else if (k < 83) c = 1;
      else if (k < 84) r = 1;
      else if (k < 95) begin
        c = ($urandom_range(0, 9) < 2); e = ($urandom_range(0, 9) < 3);
        o = ($urandom_range(0, 9) < 3); b = ($urandom_range(0, 9) < 3);
        n = ($urandom_range(0, 9) < 3); h = ($urandom_range(0, 9) < 5);
      end
      step(r, c, e, o, b, n, h, 4'($urandom_range(0, 15)), 17'($urandom));
      ev1 = {s1, 16'(m1)};
      ev2 = {s2, 16'(m2)};
      ef  = (m_st == 0) ? (c1 == 4) : (m_st == 1) ? (c2 == 4) : 1'b0;
      tests++; if (V1curr !== ev1) begin fails++; $display("FAIL rnd_v1 @%0d got %h want %h", i, V1curr, ev1); end
      tests++; if (V2curr !== ev2) begin fails++; $display("FAIL rnd_v2 @%0d got %h want %h", i, V2curr, ev2); end
      tests++; if (edit2 !== (m_st == 1)) begin fails++; $display("FAIL rnd_edit2 @%0d got %b want %b", i, edit2, (m_st == 1)); end
      tests++; if (full !== ef) begin fails++; $display("FAIL rnd_full @%0d got %b want %b", i, full, ef); end
    end
  endtask

  initial begin
    reset = 1; newhex = 0; newop = 0; eq = 0; BS = 0; neg = 0; clr = 0;
    hexcode = 4'h0; answer = 17'h0;
    test_reset();
    test_entry();
    test_eq();
    test_saturate();
    test_chain();
    test_neg();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
